// File: rtl/sht40_pkg.sv
// Shared constants and types for the SHT40 read-frame decoder.
package sht40_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned WORD_W      = 16;
  localparam int unsigned IDX_W       = 3;
  localparam int unsigned TMO_W       = 16;
  localparam int unsigned FRAME_BYTES = 6;

  localparam logic [BYTE_W-1:0] CRC_POLY = 8'h31;
  localparam logic [BYTE_W-1:0] CRC_INIT = 8'hFF;

  // Byte positions that carry a CRC rather than data
  localparam logic [IDX_W-1:0] IDX_CRC_T = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_CRC_H = IDX_W'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_CHECK   = 2'd2
  } state_t;

endpackage

// File: rtl/sht40_crc8.sv
// One full-byte step of CRC-8 (poly 0x31, MSB first, no reflection).
module sht40_crc8
  import sht40_pkg::*;
(
  input  logic [BYTE_W-1:0] crc_in,
  input  logic [BYTE_W-1:0] data_in,
  output logic [BYTE_W-1:0] crc_out
);

  logic [BYTE_W-1:0] w_crc;

  always_comb begin
    w_crc = crc_in ^ data_in;
    for (int i = 0; i < 8; i++) begin
      w_crc = w_crc[7] ? ({w_crc[6:0], 1'b0} ^ CRC_POLY) : {w_crc[6:0], 1'b0};
    end
    crc_out = w_crc;
  end

endmodule

// File: rtl/sht40_frame_decoder.sv
// Collects a 6-byte SHT40 measurement frame, checks both CRCs and publishes
// the CRC-good temperature/humidity words.
module sht40_frame_decoder
  import sht40_pkg::*;
#(
  parameter logic [TMO_W-1:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Frame_Start,
  input  logic [BYTE_W-1:0] Rx_Byte,
  input  logic              Rx_Byte_Valid,
  output logic [WORD_W-1:0] Temp_Raw,
  output logic [WORD_W-1:0] Hum_Raw,
  output logic              Meas_Valid,
  output logic              Crc_Err_T,
  output logic              Crc_Err_H,
  output logic              Frame_Err,
  output logic              Busy
);

  state_t              r_state,      w_state_nxt;
  logic [IDX_W-1:0]    r_idx,        w_idx_nxt;
  logic [BYTE_W-1:0]   r_crc,        w_crc_nxt;
  logic [TMO_W-1:0]    r_tmo,        w_tmo_nxt;
  logic [WORD_W-1:0]   r_temp_buf,   w_temp_buf_nxt;
  logic [WORD_W-1:0]   r_hum_buf,    w_hum_buf_nxt;
  logic                r_pend_t,     w_pend_t_nxt;
  logic [WORD_W-1:0]   r_temp_raw,   w_temp_raw_nxt;
  logic [WORD_W-1:0]   r_hum_raw,    w_hum_raw_nxt;
  logic                r_meas_valid, w_meas_valid_nxt;
  logic                r_err_t,      w_err_t_nxt;
  logic                r_err_h,      w_err_h_nxt;
  logic                r_frame_err,  w_frame_err_nxt;
  logic                r_busy,       w_busy_nxt;
  logic [BYTE_W-1:0]   w_crc_step;
  logic [TMO_W-1:0]    w_tmo_inc;

  sht40_crc8 u_crc (
    .crc_in  (r_crc),
    .data_in (Rx_Byte),
    .crc_out (w_crc_step)
  );

  assign w_tmo_inc = (r_tmo == '1) ? r_tmo : r_tmo + TMO_W'(1);

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_crc        <= CRC_INIT;
      r_tmo        <= '0;
      r_temp_buf   <= '0;
      r_hum_buf    <= '0;
      r_pend_t     <= 1'b0;
      r_temp_raw   <= '0;
      r_hum_raw    <= '0;
      r_meas_valid <= 1'b0;
      r_err_t      <= 1'b0;
      r_err_h      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_crc        <= w_crc_nxt;
      r_tmo        <= w_tmo_nxt;
      r_temp_buf   <= w_temp_buf_nxt;
      r_hum_buf    <= w_hum_buf_nxt;
      r_pend_t     <= w_pend_t_nxt;
      r_temp_raw   <= w_temp_raw_nxt;
      r_hum_raw    <= w_hum_raw_nxt;
      r_meas_valid <= w_meas_valid_nxt;
      r_err_t      <= w_err_t_nxt;
      r_err_h      <= w_err_h_nxt;
      r_frame_err  <= w_frame_err_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  // Next-state and datapath; Frame_Start always wins over a same-cycle byte
  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_crc_nxt        = r_crc;
    w_tmo_nxt        = r_tmo;
    w_temp_buf_nxt   = r_temp_buf;
    w_hum_buf_nxt    = r_hum_buf;
    w_pend_t_nxt     = r_pend_t;
    w_temp_raw_nxt   = r_temp_raw;
    w_hum_raw_nxt    = r_hum_raw;
    w_meas_valid_nxt = 1'b0;
    w_err_t_nxt      = r_err_t;
    w_err_h_nxt      = r_err_h;
    w_frame_err_nxt  = 1'b0;

    if (Frame_Start) begin
      w_state_nxt     = ST_COLLECT;
      w_idx_nxt       = '0;
      w_crc_nxt       = CRC_INIT;
      w_tmo_nxt       = '0;
      w_pend_t_nxt    = 1'b0;
      w_err_t_nxt     = 1'b0;
      w_err_h_nxt     = 1'b0;
      w_frame_err_nxt = (r_state == ST_COLLECT);
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (Rx_Byte_Valid) begin
            w_tmo_nxt = '0;
            w_idx_nxt = r_idx + IDX_W'(1);
            if (r_idx == IDX_CRC_T) begin
              w_pend_t_nxt = (Rx_Byte != r_crc);
              w_crc_nxt    = CRC_INIT;
            end else if (r_idx == IDX_CRC_H) begin
              w_state_nxt      = ST_CHECK;
              w_idx_nxt        = '0;
              w_crc_nxt        = CRC_INIT;
              w_meas_valid_nxt = 1'b1;
              w_err_t_nxt      = r_pend_t;
              w_err_h_nxt      = (Rx_Byte != r_crc);
              if (!r_pend_t)        w_temp_raw_nxt = r_temp_buf;
              if (Rx_Byte == r_crc) w_hum_raw_nxt  = r_hum_buf;
            end else begin
              w_crc_nxt = w_crc_step;
              if (r_idx < IDX_CRC_T) w_temp_buf_nxt = {r_temp_buf[7:0], Rx_Byte};
              else                   w_hum_buf_nxt  = {r_hum_buf[7:0], Rx_Byte};
            end
          end else if (r_tmo >= TIMEOUT_CYCLES) begin
            w_state_nxt     = ST_IDLE;
            w_frame_err_nxt = 1'b1;
          end else begin
            w_tmo_nxt = w_tmo_inc;
          end
        end
        ST_CHECK: w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  assign Temp_Raw   = r_temp_raw;
  assign Hum_Raw    = r_hum_raw;
  assign Meas_Valid = r_meas_valid;
  assign Crc_Err_T  = r_err_t;
  assign Crc_Err_H  = r_err_h;
  assign Frame_Err  = r_frame_err;
  assign Busy       = r_busy;

endmodule

// File: tb/tb_sht40_frame_decoder.sv
// Scoreboard bench for sht40_frame_decoder: stimulus queues expected events,
// a negedge monitor pops and compares whenever Meas_Valid or Frame_Err fires.
module tb_sht40_frame_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        Frame_Start = 1'b0;
  logic [7:0]  Rx_Byte = 8'h00;
  logic        Rx_Byte_Valid = 1'b0;
  logic [15:0] Temp_Raw;
  logic [15:0] Hum_Raw;
  logic        Meas_Valid;
  logic        Crc_Err_T;
  logic        Crc_Err_H;
  logic        Frame_Err;
  logic        Busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    bit          is_meas;
    logic [15:0] temp;
    logic [15:0] hum;
    bit          et;
    bit          eh;
    int          cyc_lo;
    int          cyc_hi;
  } exp_t;

  exp_t sb[$];

  sht40_frame_decoder #(.TIMEOUT_CYCLES(16'd20)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .Frame_Start   (Frame_Start),
    .Rx_Byte       (Rx_Byte),
    .Rx_Byte_Valid (Rx_Byte_Valid),
    .Temp_Raw      (Temp_Raw),
    .Hum_Raw       (Hum_Raw),
    .Meas_Valid    (Meas_Valid),
    .Crc_Err_T     (Crc_Err_T),
    .Crc_Err_H     (Crc_Err_H),
    .Frame_Err     (Frame_Err),
    .Busy          (Busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input bit is_meas, input logic [15:0] t, input logic [15:0] h,
                              input bit et, input bit eh, input int lo, input int hi);
    exp_t e;
    e.is_meas = is_meas; e.temp = t; e.hum = h; e.et = et; e.eh = eh;
    e.cyc_lo = lo; e.cyc_hi = hi;
    return e;
  endfunction

  // Monitor: every output event must match the oldest queued expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && (Meas_Valid || Frame_Err)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_event: Meas_Valid=%0b Frame_Err=%0b at cycle %0d, none expected",
                 Meas_Valid, Frame_Err, cyc);
      end else begin
        e = sb.pop_front();
        chk("event_kind", {Meas_Valid, Frame_Err}, e.is_meas ? 2'b10 : 2'b01);
        n_checks++;
        if (cyc < e.cyc_lo || cyc > e.cyc_hi) begin
          n_errors++;
          $display("FAIL event_cycle: got %0d expected %0d..%0d", cyc, e.cyc_lo, e.cyc_hi);
        end
        chk("temp_raw", Temp_Raw, e.temp);
        chk("hum_raw", Hum_Raw, e.hum);
        if (e.is_meas) begin
          chk("crc_err_t", Crc_Err_T, e.et);
          chk("crc_err_h", Crc_Err_H, e.eh);
        end
      end
    end
  end

  // All stimulus tasks start and end on a falling edge with strobes low
  task automatic send_byte(input logic [7:0] b);
    Rx_Byte = b;
    Rx_Byte_Valid = 1'b1;
    @(negedge clk);
    Rx_Byte_Valid = 1'b0;
  endtask

  task automatic start_frame();
    Frame_Start = 1'b1;
    @(negedge clk);
    Frame_Start = 1'b0;
  endtask

  // Sends six bytes; the result must appear the cycle after the last one
  task automatic send_frame(input logic [47:0] f, input logic [15:0] t, input logic [15:0] h,
                            input bit et, input bit eh);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) sb.push_back(mk(1'b1, t, h, et, eh, cyc + 1, cyc + 1));
      send_byte(f[47 - 8*i -: 8]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_temp"}, Temp_Raw, 16'h0000);
    chk({tag, "_hum"}, Hum_Raw, 16'h0000);
    chk({tag, "_flags"}, {Meas_Valid, Crc_Err_T, Crc_Err_H, Frame_Err, Busy}, 5'b00000);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Byte strobes in IDLE do nothing
    send_byte(8'hAA);
    send_byte(8'hBE);
    chk("idle_busy", Busy, 1'b0);

    // Good frame: 0xBEEF with CRC 0x92 in both words
    start_frame();
    chk("collect_busy", Busy, 1'b1);
    send_frame(48'hBEEF92_BEEF92, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("idle_after_check", Busy, 1'b0);

    // Both CRCs bad: words keep their previous value, error levels hold
    start_frame();
    send_frame(48'hBEEF93_123400, 16'hBEEF, 16'hBEEF, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    chk("err_t_hold", Crc_Err_T, 1'b1);
    chk("err_h_hold", Crc_Err_H, 1'b1);

    // Frame_Start clears error levels; temp good (0x0000 -> 0x81), hum bad
    start_frame();
    chk("err_clear", {Crc_Err_T, Crc_Err_H}, 2'b00);
    send_frame(48'h000081_123400, 16'h0000, 16'hBEEF, 1'b0, 1'b1);
    repeat (2) @(negedge clk);

    // Temp good, hum good with a different value
    start_frame();
    send_frame(48'hBEEF92_000081, 16'hBEEF, 16'h0000, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    // Timeout after 3 bytes: one Frame_Err, no Meas_Valid, words unchanged
    start_frame();
    send_byte(8'hBE);
    send_byte(8'hEF);
    sb.push_back(mk(1'b0, 16'hBEEF, 16'h0000, 1'b0, 1'b0, cyc + 21, cyc + 23));
    send_byte(8'h92);
    repeat (25) @(negedge clk);
    chk("timeout_busy", Busy, 1'b0);

    // Restart coincident with a byte: byte dropped, new frame decodes cleanly
    start_frame();
    send_byte(8'hBE);
    send_byte(8'hEF);
    send_byte(8'h92);
    sb.push_back(mk(1'b0, 16'hBEEF, 16'h0000, 1'b0, 1'b0, cyc + 1, cyc + 1));
    Frame_Start = 1'b1;
    Rx_Byte = 8'hBE;
    Rx_Byte_Valid = 1'b1;
    @(negedge clk);
    Frame_Start = 1'b0;
    Rx_Byte_Valid = 1'b0;
    chk("restart_busy", Busy, 1'b1);
    send_frame(48'h000081_BEEF92, 16'h0000, 16'hBEEF, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    // Reset mid-frame after byte 4: outputs drop immediately
    start_frame();
    send_byte(8'hBE);
    send_byte(8'hEF);
    send_byte(8'h92);
    send_byte(8'hBE);
    send_byte(8'hEF);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h92);
    send_byte(8'hBE);
    send_byte(8'hEF);
    send_byte(8'h92);
    send_byte(8'h00);
    send_byte(8'h81);
    repeat (2) @(negedge clk);
    check_all_zero("stray_after_reset");

    // Fresh frame after reset
    start_frame();
    send_frame(48'hBEEF92_BEEF92, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      n_errors++;
      $display("FAIL missing_event: expected %s in cycles %0d..%0d, never seen",
               e.is_meas ? "Meas_Valid" : "Frame_Err", e.cyc_lo, e.cyc_hi);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sht40_frame_decoder.md
SHT40_FRAME_DECODER -- requirements
Module: sht40_frame_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd50000; max clk cycles allowed between accepted bytes within a frame.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port Frame_Start  input  1  one-cycle pulse from I2C master marking the start of an SHT40 read-data phase.
REQ-005 SHALL have port Rx_Byte  input  8  byte received from the SDA path, MSB first as on the wire.
REQ-006 SHALL have port Rx_Byte_Valid  input  1  one-cycle strobe; Rx_Byte is valid this cycle.
REQ-007 SHALL have port Temp_Raw  output  16  last CRC-good temperature word {byte0,byte1}.
REQ-008 SHALL have port Hum_Raw  output  16  last CRC-good humidity word {byte3,byte4}.
REQ-009 SHALL have port Meas_Valid  output  1  one-cycle pulse on every completed 6-byte frame.
REQ-010 SHALL have port Crc_Err_T  output  1  level; temperature CRC mismatch in the last completed frame.
REQ-011 SHALL have port Crc_Err_H  output  1  level; humidity CRC mismatch in the last completed frame.
REQ-012 SHALL have port Frame_Err  output  1  one-cycle pulse on an aborted frame (timeout or restart).
REQ-013 SHALL have port Busy  output  1  high while in COLLECT or CHECK.

Function
REQ-014 SHALL implement states IDLE, COLLECT, CHECK; IDLE->COLLECT on Frame_Start.
REQ-015 SHALL, on Frame_Start, clear byte index to 0, load running CRC to 8'hFF, clear timeout counter, clear Crc_Err_T/Crc_Err_H.
REQ-016 SHALL, in COLLECT, accept one byte per Rx_Byte_Valid, increment byte index 0..5, clear timeout counter.
REQ-017 SHALL compute CRC-8, poly 0x31, init 0xFF, no reflection, no final XOR, updated one full byte per cycle.
REQ-018 SHALL, at index 2, compare received byte to CRC of bytes 0-1, register the result, and reload CRC to 8'hFF; likewise at index 5 for bytes 3-4.
REQ-019 SHALL enter CHECK the cycle after byte 5 is accepted, and in CHECK pulse Meas_Valid, drive Crc_Err_T/H, update Temp_Raw only if temperature CRC passed, update Hum_Raw only if humidity CRC passed, then return to IDLE.
REQ-020 SHALL give latency: byte 5 accepted at cycle N -> Meas_Valid high at N+1 exactly one cycle.
REQ-021 SHALL ignore Rx_Byte_Valid in IDLE and CHECK without state change.
REQ-022 SHALL, when the timeout counter reaches TIMEOUT_CYCLES in COLLECT, pulse Frame_Err next cycle, return to IDLE, and leave Temp_Raw/Hum_Raw unchanged.
REQ-023 SHALL, on Frame_Start while in COLLECT, pulse Frame_Err and restart the frame per REQ-015, staying in COLLECT.
REQ-024 SHALL give Frame_Start priority over a simultaneous Rx_Byte_Valid; that byte is discarded.
REQ-025 SHALL hold Crc_Err_T/H levels until the next Frame_Start or reset.
REQ-026 SHALL saturate the timeout counter and never wrap.

Reset
REQ-027 SHALL, on rst_n low, immediately force state IDLE, byte index 0, CRC 8'hFF, counters 0, and all outputs 0, including mid-frame.
REQ-028 SHALL resume operation on the first rising clk edge after rst_n deasserts, requiring a fresh Frame_Start.

Structure
REQ-029 SHALL place state encodings, CRC_POLY 8'h31, CRC_INIT 8'hFF and FRAME_BYTES 6 in shared package sht40_pkg.
REQ-030 SHALL implement the byte-wide CRC step as combinational sub-module sht40_crc8 (crc_in, data_in -> crc_out).

Verification
REQ-031 SHALL cover: Frame_Start, bytes BE EF 92 BE EF 92 -> Meas_Valid one cycle after last byte, Temp_Raw=Hum_Raw=16'hBEEF, both Crc_Err 0.
REQ-032 SHALL cover: good frame, then bytes BE EF 93 12 34 xx (bad both) -> Meas_Valid, Crc_Err_T=Crc_Err_H=1, Temp_Raw/Hum_Raw still 16'hBEEF.
REQ-033 SHALL cover: TIMEOUT_CYCLES=20, 3 bytes then idle 25 cycles -> single Frame_Err pulse, no Meas_Valid, Busy low.
REQ-034 SHALL cover: Frame_Start coincident with Rx_Byte_Valid after byte 2 -> Frame_Err pulse, that byte dropped, following 6 good bytes yield correct Meas_Valid.
REQ-035 SHALL cover: rst_n asserted after byte 4 -> outputs 0 immediately, subsequent stray Rx_Byte_Valid ignored until Frame_Start.
